// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared bus defines, AXI response codes and FSM encoding for ifu_fetch
// Optional feature macro used by ifu_fetch: IFU_RRESP_CHECK_EN
`ifndef IFU_FETCH_DEFINES
`define IFU_FETCH_DEFINES
`define RST_ENABLE 1'b0
`define INST_ADDR_BUS 31:0
`define INST_DATA_BUS 31:0
`endif

package ifu_fetch_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_EXOKAY = 2'b01;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;
  localparam logic [1:0] RRESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ifu_pc.sv
// rtl/ifu_pc.sv - fetch PC register with +4 advance, redirect load and squash target latch
module ifu_pc
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  advance,
  input  logic                  squash_set,
  input  logic                  squash_done,
  input  logic                  redirect,
  input  logic [`INST_ADDR_BUS] redirect_pc,
  output logic [`INST_ADDR_BUS] pc,
  output logic                  squash
);

  logic [`INST_ADDR_BUS] target;
  logic [`INST_ADDR_BUS] pc_n;

  // A redirect arriving in the same cycle the squashed read completes is the newest target.
  always_comb begin
    pc_n = pc;
    if (load)
      pc_n = redirect_pc;
    else if (squash_done)
      pc_n = redirect ? redirect_pc : target;
    else if (advance)
      pc_n = pc + 32'd4;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == `RST_ENABLE) begin
      pc     <= RESET_PC;
      target <= RESET_PC;
      squash <= 1'b0;
    end else begin
      pc <= pc_n;
      if (squash_set)
        target <= redirect_pc;
      if (squash_done)
        squash <= 1'b0;
      else if (squash_set)
        squash <= 1'b1;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch: one AXI4-Lite read per instruction into the IF/ID handshake
// Optional: define IFU_RRESP_CHECK_EN to report non-OKAY read responses on fault_o.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  output logic [`INST_ADDR_BUS] araddr_o,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  input  logic [`INST_DATA_BUS] rdata_i,
  input  logic [1:0]            rresp_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [`INST_ADDR_BUS] pc_o,
  output logic [`INST_DATA_BUS] inst_o,
  output logic                  fault_o,
  input  logic                  redirect_i,
  input  logic [`INST_ADDR_BUS] redirect_pc_i
);

  fetch_state_e          state, state_n;
  logic                  hold_q;
  logic [`INST_ADDR_BUS] pc;
  logic                  squash;
  logic                  in_idle, in_ar, in_r, in_hold;
  logic                  r_done, squash_now, capture, accept;

  assign in_idle    = (state == S_IDLE);
  assign in_ar      = (state == S_AR);
  assign in_r       = (state == S_R);
  assign in_hold    = (state == S_HOLD);
  assign r_done     = in_r & rvalid_i;
  assign squash_now = squash | redirect_i;
  assign capture    = r_done & ~squash_now;
  assign accept     = in_hold & ~redirect_i & ready_i;

  ifu_pc #(.RESET_PC(RESET_PC)) u_pc (
    .clk         (clk),
    .rst         (rst),
    .load        (redirect_i & (in_idle | in_hold)),
    .advance     (accept),
    .squash_set  (redirect_i & (in_ar | (in_r & ~rvalid_i))),
    .squash_done (r_done & squash_now),
    .redirect    (redirect_i),
    .redirect_pc (redirect_pc_i),
    .pc          (pc),
    .squash      (squash)
  );

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: state_n = S_AR;
      S_AR:   if (arready_i) state_n = S_R;
      S_R:    if (rvalid_i) state_n = squash_now ? S_AR : S_HOLD;
      S_HOLD: if (redirect_i | ready_i) state_n = S_AR;
      default: state_n = S_IDLE;
    endcase
  end

  // Handshake flags are flopped from the next state so they leave the block glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == `RST_ENABLE) begin
      state     <= S_IDLE;
      arvalid_o <= 1'b0;
      rready_o  <= 1'b0;
      hold_q    <= 1'b0;
      pc_o      <= '0;
      inst_o    <= '0;
    end else begin
      state     <= state_n;
      arvalid_o <= (state_n == S_AR);
      rready_o  <= (state_n == S_R);
      hold_q    <= (state_n == S_HOLD);
      if (capture) begin
        pc_o   <= pc;
        inst_o <= rdata_i;
      end
    end
  end

  assign araddr_o = pc;
  assign valid_o  = hold_q & ~redirect_i;

`ifdef IFU_RRESP_CHECK_EN
  logic fault_q;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == `RST_ENABLE)
      fault_q <= 1'b0;
    else if (capture)
      fault_q <= (rresp_i != RRESP_OKAY);
    else if (in_hold & (ready_i | redirect_i))
      fault_q <= 1'b0;
  end

  assign fault_o = fault_q;
`else
  logic unused_rresp;
  assign unused_rresp = ^rresp_i;
  assign fault_o      = 1'b0;
`endif

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction-fetch unit of the multi-cycle NPC core: holds the PC, issues one AXI4-Lite read per instruction to instruction memory, and presents the fetched word plus its address to the IF/ID pipeline register under a valid/ready handshake. It is the producer side of that register: the IF/ID register's write enable is `valid_o & ready_i`, and its address and data inputs are `pc_o` and `inst_o`. A redirect port from the execute/writeback stage steers fetch to a new PC and squashes wrong-path instructions.

## Interface
- RESET_PC, 32'h8000_0000, first fetch address after reset
- clk  input  1  clock, all state on posedge
- rst  input  1  asynchronous, active-low reset (`RST_ENABLE` = 0)
- arvalid_o  output  1  AXI AR valid
- arready_i  input  1  AXI AR ready
- araddr_o  output  `INST_ADDR_BUS`  AXI AR address
- rvalid_i  input  1  AXI R valid
- rready_o  output  1  AXI R ready
- rdata_i  input  `INST_DATA_BUS`  AXI R data
- rresp_i  input  2  AXI R response
- valid_o  output  1  fetched instruction available to IDU
- ready_i  input  1  IDU accepts instruction
- pc_o  output  `INST_ADDR_BUS`  address of presented instruction
- inst_o  output  `INST_DATA_BUS`  presented instruction word
- fault_o  output  1  presented instruction had a bus error
- redirect_i  input  1  one-cycle request to restart fetch at redirect_pc_i
- redirect_pc_i  input  `INST_ADDR_BUS`  redirect target

## Operation
- FSM states: IDLE, AR, R, HOLD. Reset → IDLE; IDLE → AR unconditionally on the next edge.
- AR: arvalid_o=1 and araddr_o=pc. On arvalid_o & arready_i → R. Once asserted, arvalid_o and araddr_o stay stable until the handshake.
- R: rready_o=1. On rvalid_i → HOLD; rdata_i is captured into inst_o, pc into pc_o, and the rresp result into fault_o.
- HOLD: valid_o = ~redirect_i. On valid_o & ready_i: pc ← pc + 4, → AR.
- Redirect in AR or R: set squash flag and latch redirect_pc_i as the target. The AXI transaction completes normally. On rvalid_i the data is dropped, pc ← target, squash is cleared, and the FSM goes to AR (skips HOLD).
- Redirect in HOLD: valid_o is forced 0 in that cycle, pc ← redirect_pc_i, → AR. Redirect wins over a simultaneous ready_i.
- Redirect in IDLE: pc ← redirect_pc_i.
- A second redirect before the squash completes overwrites the target; the newest target wins.
- pc arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 → 32'h0000_0000. No alignment check.

## Timing
- Reset values: arvalid_o=0, rready_o=0, valid_o=0, fault_o=0, pc_o=0, inst_o=0, araddr_o=RESET_PC, internal pc=RESET_PC, squash=0.
- Reset mid-transaction aborts immediately to IDLE with the values above. The memory side is reset by the same rst.
- Best case with arready_i=1 and rvalid_i one cycle later: arvalid_o rises 1 cycle after reset release. valid_o rises 2 cycles after the AR handshake. Minimum rate is 1 instruction per 3 cycles at ready_i=1.
- pc_o, inst_o and fault_o hold stable from HOLD entry until the handshake. After a handshake they keep their last values.
- valid_o has a combinational path from redirect_i only. All other outputs are registered.

## Configuration
- IFU_RRESP_CHECK_EN defined: when rresp_i != 2'b00 at R completion, fault_o=1 in HOLD. inst_o still carries rdata_i. fault_o clears on the HOLD handshake or on a redirect.
- IFU_RRESP_CHECK_EN undefined: rresp_i is ignored and fault_o is tied to 0.

## Structure
- Shared defines: `RST_ENABLE`, `INST_ADDR_BUS`, `INST_DATA_BUS`, the AXI RRESP codes (OKAY=2'b00) and the ifu_fetch FSM state encoding.
- One sub-module, `ifu_pc`: PC register, +4 adder, redirect target/squash latch and next-PC mux. The FSM and AXI/handshake logic stay in ifu_fetch.

## Test plan
- Reset release, arready_i=1, rvalid_i one cycle after AR with rdata 32'h0010_0093, ready_i=1 → araddr_o=32'h8000_0000; valid_o with pc_o=32'h8000_0000 and inst_o=32'h0010_0093; next araddr_o=32'h8000_0004.
- ready_i=0 for 5 cycles in HOLD → valid_o, pc_o and inst_o stay stable, arvalid_o=0. ready_i=1 → next AR issued the following cycle.
- arready_i low for 3 cycles → arvalid_o and araddr_o stay stable throughout; redirect_i to 32'h8000_0100 during AR → fetched word dropped, valid_o never rises, next araddr_o=32'h8000_0100.
- redirect_i together with ready_i in HOLD → valid_o=0 that cycle, no IDU write, next araddr_o=redirect_pc_i.
- rresp_i=2'b10 with IFU_RRESP_CHECK_EN defined → fault_o=1 alongside valid_o. Same stimulus with the macro undefined → fault_o=0.
- rst asserted while in R → all outputs return to reset values at once; fetch restarts at 32'h8000_0000.
